trap_controller: RTL

Machine-mode interrupt sequencer for the core. Latches edges on NUM_SRC interrupt lines, picks the highest-priority enabled one, and stalls and drains the pipeline. It then pulses the CSR register file to save mepc/mcause and clear MIE, redirects fetch to the handler, and returns to mepc on mret. It sits between the interrupt sources, the CSR register file and the fetch/PC stage. It owns the trap-entry and trap-exit sequence; the CSR register file only stores the values.

---
 rtl/trap_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/trap_controller.sv
// ---------------------------------------------------------------------------
// trap_controller
//
// Machine-mode interrupt sequencer. It latches rising edges on the interrupt
// lines and picks the lowest-index enabled pending source. It then stalls and
// drains the pipeline, pulses the CSR file to save mepc/mcause, and redirects
// fetch to the handler. On mret it redirects fetch back to mepc.
//
// Optional feature macro: TRAP_CTRL_VECTORED_EN
//   defined     : redirect_pc = mtvec base + 4*(CAUSE_BASE+win_idx) (vectored)
//   not defined : redirect_pc = mtvec base for every source (direct)
//
// Ports
//   clock_i          clock, all state on rising edge
//   reset_i          synchronous active-high reset
//   irq_src_i        level interrupt lines (rising edge sets pending)
//   irq_mask_i       per-source enable (mie bits)
//   global_ie_i      mstatus.MIE
//   pipe_idle_i      pipeline drained acknowledge
//   pc_current_i     PC of the oldest unretired instruction
//   mtvec_i          handler base, bits [1:0] ignored
//   mepc_i           return address for mret
//   mret_i           one-cycle pulse when mret retires
//   stall_req_o      freezes fetch/issue
//   trap_take_o      one-cycle pulse: CSR file saves epc/cause, clears MIE
//   trap_cause_o     {1'b1, 31-bit code}
//   trap_epc_o       saved PC, held until the next trap
//   redirect_valid_o one-cycle pulse: fetch loads redirect_pc_o
//   redirect_pc_o    new fetch address
//   in_trap_o        handler is running
//   pending_o        latched pending bits
// ---------------------------------------------------------------------------
module trap_controller #(
   parameter int NUM_SRC    = 4,
   parameter int CAUSE_BASE = 11
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic [NUM_SRC-1:0] irq_src_i,
   input  logic [NUM_SRC-1:0] irq_mask_i,
   input  logic               global_ie_i,
   input  logic               pipe_idle_i,
   input  logic [31:0]        pc_current_i,
   input  logic [31:0]        mtvec_i,
   input  logic [31:0]        mepc_i,
   input  logic               mret_i,
   output logic               stall_req_o,
   output logic               trap_take_o,
   output logic [31:0]        trap_cause_o,
   output logic [31:0]        trap_epc_o,
   output logic               redirect_valid_o,
   output logic [31:0]        redirect_pc_o,
   output logic               in_trap_o,
   output logic [NUM_SRC-1:0] pending_o
);

   // Fixed index width covers the full 1..16 source range.
   localparam int IDX_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_SAVE,
      ST_REDIRECT,
      ST_IN_TRAP,
      ST_RETURN
   } state_t;

   state_t             state_q;
   logic [NUM_SRC-1:0] irq_prev_q;
   logic [NUM_SRC-1:0] pending_q;
   logic [NUM_SRC-1:0] pending_d;
   logic [IDX_W-1:0]   win_idx_q;
   logic [31:0]        trap_epc_q;
   logic [31:0]        trap_cause_q;
   logic               stall_req_q;
   logic               trap_take_q;
   logic               redirect_valid_q;
   logic [31:0]        redirect_pc_q;
   logic               in_trap_q;

   logic [NUM_SRC-1:0] irq_rise;
   logic [NUM_SRC-1:0] enabled;
   logic [NUM_SRC-1:0] clr_vec;
   logic [IDX_W-1:0]   sel_idx;
   logic [30:0]        cause_code;
   logic [31:0]        tvec_base;
   logic [31:0]        handler_pc;
   logic [1:0]         unused_tvec_bits;

   assign irq_rise         = irq_src_i & ~irq_prev_q;
   assign enabled          = pending_q & irq_mask_i;
   assign unused_tvec_bits = mtvec_i[1:0];

   // The winner is cleared only while in SAVE; a same-cycle rising edge on
   // that line re-sets it because the set term is ORed in last.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_clr
      assign clr_vec[gi] = (state_q == ST_SAVE) && (win_idx_q == IDX_W'(gi));
   end

   assign pending_d = (pending_q & ~clr_vec) | irq_rise;

   // Lowest set index wins: scan downward so the smallest index is written last.
   always_comb begin
      sel_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (enabled[i]) begin
            sel_idx = IDX_W'(i);
         end
      end
   end

   assign cause_code = 31'(CAUSE_BASE) + 31'(win_idx_q);
   assign tvec_base  = {mtvec_i[31:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
   assign handler_pc = tvec_base + {cause_code[29:0], 2'b00};
`else
   assign handler_pc = tvec_base;
`endif

   // Outputs are registered alongside the state: each branch loads the
   // output values belonging to the state being entered.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q          <= ST_IDLE;
         irq_prev_q       <= '0;
         pending_q        <= '0;
         win_idx_q        <= '0;
         trap_epc_q       <= '0;
         trap_cause_q     <= '0;
         stall_req_q      <= 1'b0;
         trap_take_q      <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         in_trap_q        <= 1'b0;
      end else begin
         irq_prev_q       <= irq_src_i;
         pending_q        <= pending_d;
         stall_req_q      <= 1'b0;
         trap_take_q      <= 1'b0;
         trap_cause_q     <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         in_trap_q        <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (global_ie_i && (|enabled)) begin
                  win_idx_q   <= sel_idx;
                  state_q     <= ST_DRAIN;
                  stall_req_q <= 1'b1;
               end
            end
            ST_DRAIN: begin
               // win_idx_q stays frozen here regardless of pending/mask.
               stall_req_q <= 1'b1;
               if (pipe_idle_i) begin
                  trap_epc_q   <= pc_current_i;
                  state_q      <= ST_SAVE;
                  trap_take_q  <= 1'b1;
                  trap_cause_q <= {1'b1, cause_code};
               end
            end
            ST_SAVE: begin
               state_q          <= ST_REDIRECT;
               redirect_valid_q <= 1'b1;
               redirect_pc_q    <= handler_pc;
            end
            ST_REDIRECT: begin
               state_q   <= ST_IN_TRAP;
               in_trap_q <= 1'b1;
            end
            ST_IN_TRAP: begin
               // No nesting: new pending bits wait until after RETURN.
               if (mret_i) begin
                  state_q          <= ST_RETURN;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= mepc_i;
               end else begin
                  in_trap_q <= 1'b1;
               end
            end
            ST_RETURN: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign stall_req_o      = stall_req_q;
   assign trap_take_o      = trap_take_q;
   assign trap_cause_o     = trap_cause_q;
   assign trap_epc_o       = trap_epc_q;
   assign redirect_valid_o = redirect_valid_q;
   assign redirect_pc_o    = redirect_pc_q;
   assign in_trap_o        = in_trap_q;
   assign pending_o        = pending_q;

endmodule
